stream_burst_ctrl: RTL
======================

# stream_burst_ctrl

Packet-burst scheduler placed between a stream generator (e.g. a file source) and the noc_shell stream-source port of a compute-engine block. It gates the generator's AXI-stream output into bursts of a programmed number of whole packets, inserts a programmable idle gap between packets, and supports single-shot or continuous operation. It is configured through the noc_shell settings bus and never truncates a packet, except when reset.

## Interface
- BASE, 128, first settings-register address owned by this block
- GAP_WIDTH, 16, width of the inter-packet gap counter
- clk  in  1  compute-engine clock; one clock domain for the whole block
- reset  in  1  synchronous, active-high reset
- set_stb  in  1  settings write strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- i_tdata  in  64  generator stream data
- i_tlast  in  1  generator end of packet
- i_tvalid  in  1  generator valid
- i_tready  out  1  ready back to generator
- o_tdata  out  64  stream to noc_shell str_src
- o_tlast  out  1  end of packet
- o_tvalid  out  1  valid
- o_tready  in  1  ready from noc_shell
- busy  out  1  high in any state other than IDLE
- burst_done  out  1  one-cycle pulse when a burst completes or a stop takes effect
- pkt_count  out  32  packets sent since the last start, for readback

## Operation
- Registers:
  - BASE+0 CTRL: bit0 is start, bit1 is continuous, bit2 is stop. Start and stop are write-only pulses.
  - BASE+1 NUM_PKTS: packets per burst (32 bit).
  - BASE+2 GAP: idle cycles between packets, in [GAP_WIDTH-1:0].
- States are IDLE, PASS, GAP.
- IDLE:
  - i_tready=0 and o_tvalid=0. The generator is back-pressured; no data is dropped.
  - A CTRL write with start=1 and NUM_PKTS≠0 latches NUM_PKTS and continuous into shadow registers, clears pkt_count, and moves to PASS.
  - A start with NUM_PKTS=0 is ignored.
- PASS:
  - Combinational pass-through: o_tdata/o_tlast = i_tdata/i_tlast, o_tvalid = i_tvalid, i_tready = o_tready.
  - On each tlast handshake (o_tvalid & o_tready & o_tlast), pkt_count increments by 1.
- After a packet ends (tlast handshake):
  - If a stop is pending, or the count reaches the shadow NUM_PKTS and continuous=0: go to IDLE and pulse burst_done.
  - If the count reaches NUM_PKTS and continuous=1: pulse burst_done, reload the shadow NUM_PKTS from the current register, and clear the internal burst counter. pkt_count keeps accumulating (wraps modulo 2^32).
  - Otherwise: if GAP≠0, load the gap counter with GAP and go to GAP; if GAP=0, stay in PASS (back-to-back packets).
- GAP:
  - Outputs gated as in IDLE.
  - The counter decrements each cycle; at 1 the block returns to PASS.
  - A stop in GAP goes to IDLE on the next cycle and pulses burst_done.
- Stop:
  - In PASS it is latched as pending and takes effect only at the next tlast handshake.
  - In IDLE it is ignored.
- Start while busy is ignored.
- NUM_PKTS/GAP writes are allowed at any time. NUM_PKTS takes effect at the next start or continuous reload; GAP takes effect at the next gap load.

## Timing
- Reset values: state IDLE, busy=0, burst_done=0, pkt_count=0, i_tready=0, o_tvalid=0. o_tdata and o_tlast follow their inputs.
- Registers CTRL/NUM_PKTS/GAP reset to 0.
- Reset mid-packet returns to IDLE next cycle. The downstream truncated packet is accepted behaviour.
- Start written at cycle N: PASS at N+1, first beat can transfer in N+1.
- Pass-through latency is zero cycles; there is no internal buffering.
- Final tlast handshake at cycle M: burst_done=1 in M+1 and busy=0 in M+1.
- Gap G after a tlast at M: outputs gated in M+1..M+G, pass resumes at M+G+1.
- Simultaneous start and stop in one CTRL write: start wins if IDLE (stop then discarded). Stop is latched if busy.
- Counter widths: pkt_count and the burst counter are 32 bit. The comparison is an equality test, made on the count after increment.

## Structure
- Shared package holds:
  - register offsets SR_CTRL=0, SR_NUM_PKTS=1, SR_GAP=2 (added to BASE)
  - CTRL bit indices
  - the state enum
- Sub-module: three setting_reg instances for the registers. The start and stop pulses are decoded directly from set_stb & set_addr==BASE+0.
- Target implementation size is about 150–250 lines of RTL.

## Test plan
- NUM_PKTS=3, GAP=0, start, generator sends 8-beat packets with o_tready=1 → exactly 24 beats out, burst_done at the cycle after the 3rd tlast, pkt_count=3, then i_tready=0.
- NUM_PKTS=2, GAP=5 → exactly 5 cycles of o_tvalid=0 between tlast #1 and the first beat of packet 2.
- Continuous, NUM_PKTS=2; stop mid-packet 4 → packet 4 completes fully, busy drops the cycle after its tlast, pkt_count=4, burst_done pulses after pkts 2 and 4.
- Random o_tready back-pressure (50%), NUM_PKTS=4 → output beats match input beats in order; no beat duplicated or lost.
- NUM_PKTS=0 then start → busy stays 0. Start while busy → no effect on the counts.
- Reset asserted mid-packet → busy=0, o_tvalid=0, pkt_count=0 next cycle. A new start then works normally.

Source files
------------

// File: rtl/stream_burst_ctrl_pkg.sv
// Purpose : shared register map, CTRL bit positions and FSM state type for stream_burst_ctrl.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package stream_burst_ctrl_pkg;

  // Register offsets relative to the block's BASE settings address
  localparam int SR_CTRL     = 0;
  localparam int SR_NUM_PKTS = 1;
  localparam int SR_GAP      = 2;

  // CTRL register bit positions
  localparam int CTRL_START = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_STOP  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/stream_burst_ctrl_if.sv
// Purpose : settings bus plus generator-side and noc_shell-side AXI-stream signals.
// Latency : n/a (wiring only).
// Backpr. : tready on each stream; the settings bus has no backpressure.
// Ports   : master = environment (drives settings, i_* data, o_tready);
//           slave  = stream_burst_ctrl (drives i_tready and o_* data).
interface stream_burst_ctrl_if;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;

  logic [63:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;

  logic [63:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;

  modport master (
    output set_stb, set_addr, set_data,
    output i_tdata, i_tlast, i_tvalid,
    input  i_tready,
    input  o_tdata, o_tlast, o_tvalid,
    output o_tready
  );

  modport slave (
    input  set_stb, set_addr, set_data,
    input  i_tdata, i_tlast, i_tvalid,
    output i_tready,
    output o_tdata, o_tlast, o_tvalid,
    input  o_tready
  );

endinterface

// File: rtl/stream_burst_ctrl_setting_reg.sv
// Purpose : one settings-bus register; captures set_data when the strobe hits ADDR.
// Latency : written value visible the cycle after the strobe.
// Backpr. : none; every matching strobe is accepted.
// Ports   : clk, reset (sync, active-high), set_stb/set_addr/set_data (data pre-sliced
//           to WIDTH by the caller), out = current register value (resets to 0).
module stream_burst_ctrl_setting_reg #(
  parameter logic [7:0] ADDR  = 8'd0,
  parameter int         WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [WIDTH-1:0] set_data,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else if (set_stb && (set_addr == ADDR)) begin
      out <= set_data;
    end
  end

endmodule

// File: rtl/stream_burst_ctrl.sv
// Purpose : gates a generator stream into bursts of whole packets with optional inter-packet gaps.
// Latency : zero-cycle combinational pass-through while passing; no internal buffering.
// Backpr. : i_tready = o_tready while passing; generator held off (i_tready=0) when idle or in a gap.
// Ports   : clk, reset (sync, active-high); bus = settings bus + both stream sides (slave modport);
//           busy (not idle), burst_done (1-cycle pulse), pkt_count (packets since last start).
module stream_burst_ctrl
  import stream_burst_ctrl_pkg::*;
#(
  parameter int BASE      = 128,
  parameter int GAP_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  stream_burst_ctrl_if.slave  bus,
  output logic                busy,
  output logic                burst_done,
  output logic [31:0]         pkt_count
);

  localparam logic [7:0] ADDR_CTRL     = 8'(BASE + SR_CTRL);
  localparam logic [7:0] ADDR_NUM_PKTS = 8'(BASE + SR_NUM_PKTS);
  localparam logic [7:0] ADDR_GAP      = 8'(BASE + SR_GAP);
  localparam logic [GAP_WIDTH-1:0] GAP_ONE = GAP_WIDTH'(1);

  // ---------------------------------------------------------------- registers
  logic                 cont_q;
  logic [31:0]          num_pkts_q;
  logic [GAP_WIDTH-1:0] gap_q;

  // Only the continuous bit is stored from CTRL; start/stop are pulses.
  stream_burst_ctrl_setting_reg #(.ADDR(ADDR_CTRL), .WIDTH(1)) u_reg_ctrl (
    .clk      (clk),
    .reset    (reset),
    .set_stb  (bus.set_stb),
    .set_addr (bus.set_addr),
    .set_data (bus.set_data[CTRL_CONT]),
    .out      (cont_q)
  );

  stream_burst_ctrl_setting_reg #(.ADDR(ADDR_NUM_PKTS), .WIDTH(32)) u_reg_num_pkts (
    .clk      (clk),
    .reset    (reset),
    .set_stb  (bus.set_stb),
    .set_addr (bus.set_addr),
    .set_data (bus.set_data),
    .out      (num_pkts_q)
  );

  stream_burst_ctrl_setting_reg #(.ADDR(ADDR_GAP), .WIDTH(GAP_WIDTH)) u_reg_gap (
    .clk      (clk),
    .reset    (reset),
    .set_stb  (bus.set_stb),
    .set_addr (bus.set_addr),
    .set_data (bus.set_data[GAP_WIDTH-1:0]),
    .out      (gap_q)
  );

  logic ctrl_wr;
  logic start_req;
  logic stop_req;

  assign ctrl_wr   = bus.set_stb && (bus.set_addr == ADDR_CTRL);
  assign start_req = ctrl_wr && bus.set_data[CTRL_START];
  assign stop_req  = ctrl_wr && bus.set_data[CTRL_STOP];

  // ---------------------------------------------------------------- datapath
  state_t               state;
  logic [31:0]          shadow_num;
  logic                 shadow_cont;
  logic [31:0]          burst_cnt;
  logic [GAP_WIDTH-1:0] gap_cnt;
  logic                 stop_pend;

  logic        passing;
  logic        last_hs;
  logic [31:0] burst_next;
  logic        burst_hit;

  assign passing = (state == ST_PASS);

  assign bus.o_tdata  = bus.i_tdata;
  assign bus.o_tlast  = bus.i_tlast;
  assign bus.o_tvalid = passing && bus.i_tvalid;
  assign bus.i_tready = passing && bus.o_tready;

  assign last_hs    = passing && bus.i_tvalid && bus.o_tready && bus.i_tlast;
  assign burst_next = burst_cnt + 32'd1;
  assign burst_hit  = (burst_next == shadow_num);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      burst_done  <= 1'b0;
      pkt_count   <= '0;
      shadow_num  <= '0;
      shadow_cont <= 1'b0;
      burst_cnt   <= '0;
      gap_cnt     <= '0;
      stop_pend   <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          stop_pend <= 1'b0;
          // Continuous comes from the write itself: the register copy only updates next cycle.
          if (start_req && (num_pkts_q != 32'd0)) begin
            shadow_num  <= num_pkts_q;
            shadow_cont <= bus.set_data[CTRL_CONT];
            pkt_count   <= '0;
            burst_cnt   <= '0;
            state       <= ST_PASS;
            busy        <= 1'b1;
          end
        end

        ST_PASS: begin
          if (stop_req) stop_pend <= 1'b1;
          if (last_hs) begin
            pkt_count <= pkt_count + 32'd1;
            // A stop arriving on the very tlast beat counts as pending for that packet.
            if (stop_pend || stop_req || (burst_hit && !shadow_cont)) begin
              state      <= ST_IDLE;
              busy       <= 1'b0;
              burst_done <= 1'b1;
              stop_pend  <= 1'b0;
            end else if (burst_hit) begin
              // Continuous rollover: next burst picks up the live NUM_PKTS and continuous bit,
              // so clearing continuous without a stop lets the next burst be the last.
              burst_done  <= 1'b1;
              shadow_num  <= num_pkts_q;
              shadow_cont <= cont_q;
              burst_cnt   <= '0;
            end else begin
              burst_cnt <= burst_next;
              if (gap_q != '0) begin
                gap_cnt <= gap_q;
                state   <= ST_GAP;
              end
            end
          end
        end

        ST_GAP: begin
          if (stop_req) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            burst_done <= 1'b1;
            stop_pend  <= 1'b0;
          end else if (gap_cnt <= GAP_ONE) begin
            state <= ST_PASS;
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
